fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Multi-cycle instruction fetch sequencer sitting between the PC/next-PC logic and an instruction memory that uses a req/ack handshake. It holds the fetch PC and drives one outstanding memory request at a time. It hands each fetched instruction to decode over a valid/ready interface. Redirects from execute (taken branch or jump target) squash wrong-path work, including a request already in flight.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.
PC_STEP, 4, sequential increment in bytes.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
stall  in  1  hazard hold; blocks issue of a new request.
redirect  in  1  execute-stage redirect strobe (branch taken or jump).
redirect_pc  in  32  redirect target, valid when redirect=1.
imem_req  out  1  request to instruction memory.
imem_addr  out  32  request address; stable while imem_req=1.
imem_ack  in  1  memory completion; imem_rdata valid this cycle.
imem_rdata  in  32  instruction word.
if_valid  out  1  fetched instruction valid to decode.
if_pc  out  32  PC of if_inst.
if_inst  out  32  fetched instruction.
id_ready  in  1  decode accepts the instruction.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Registers: pc (next fetch address), imem_addr, if_pc, if_inst, if_valid, and a 2-bit state. All outputs are registered except busy, which is decoded from state.
- Reset (rst_n=0 at a clk edge), regardless of state or in-flight request: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_inst=0. Any ack that arrives after reset is ignored.
- States:
  - IDLE: no request outstanding.
  - FETCH: imem_req=1 and waiting for ack.
  - HOLD: if_valid=1 and waiting for decode.
  - KILL: a squashed request is still outstanding; imem_req stays 1 and imem_addr is unchanged.
- Issue rule (applies when leaving IDLE/HOLD/KILL towards FETCH): only if stall=0. On issue, imem_addr<=pc, imem_req<=1, state<=FETCH. If stall=1, go to IDLE instead.
- IDLE:
  - redirect=1: pc<=redirect_pc and stay in IDLE this cycle.
  - Otherwise apply the issue rule.
- FETCH:
  - imem_ack=1, redirect=0: if_inst<=imem_rdata, if_pc<=imem_addr, if_valid<=1, pc<=imem_addr+PC_STEP, imem_req<=0, state<=HOLD.
  - imem_ack=1, redirect=1: discard rdata, pc<=redirect_pc, imem_req<=0, then apply the issue rule on the next cycle from IDLE.
  - imem_ack=0, redirect=1: pc<=redirect_pc, state<=KILL.
  - stall does not abort an outstanding request.
- HOLD:
  - Transfer happens when if_valid & id_ready & !redirect. On transfer: if_valid<=0, then apply the issue rule.
  - redirect=1 (overrides id_ready): if_valid<=0, pc<=redirect_pc, then apply the issue rule on the next cycle from IDLE.
  - if_pc and if_inst hold their values while if_valid=1.
- KILL:
  - redirect=1: pc<=redirect_pc; the latest redirect wins.
  - imem_ack=1: discard rdata, imem_req<=0, state<=IDLE.
  - if_valid is never set by a KILL ack.
- Memory protocol: imem_addr is constant while imem_req=1, and imem_req stays asserted until the ack cycle. There is never more than one request outstanding. A zero-wait memory (ack in the first req cycle) is legal.
- Throughput: with zero-wait memory, stall=0 and id_ready=1, the block delivers one instruction every 3 cycles (FETCH -> HOLD -> IDLE -> FETCH).
- Arithmetic: PC arithmetic is 32-bit modulo, so 0xFFFF_FFFC+4 wraps to 0. No alignment checks are made; redirect_pc is used verbatim.

Test Plan:
- Reset, then stall=0, zero-wait memory with rdata=0x2402_0001, id_ready=1:
  - imem_req rises 1 cycle after reset release with imem_addr=0.
  - if_valid=1, if_pc=0, if_inst=0x2402_0001 on the next cycle.
  - The next request is issued at imem_addr=4.
- Memory ack delayed 3 cycles: imem_req and imem_addr=0x10 are stable for all 3 cycles. Assert stall during the wait -> the request still completes, and no new request is issued until stall=0.
- Redirect to 0x400 while FETCH at addr 0x8 with no ack:
  - State goes to KILL and imem_addr stays 0x8.
  - The ack yields if_valid=0.
  - The next request goes to imem_addr=0x400.
- Redirect to 0x80 in HOLD with id_ready=1 in the same cycle: no transfer occurs, if_valid drops, and the next request goes to imem_addr=0x80.
- Two redirects in KILL (0x100, then 0x200) followed by an ack -> the next imem_addr is 0x200.
- Assert rst_n=0 mid-KILL, with an ack arriving during reset -> all outputs are 0, and the first request after release is at imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle instruction fetch sequencer.
//
// Keeps the next fetch PC and has at most one request in flight to a
// req/ack instruction memory. Each returned word goes to decode through a
// valid/ready register stage. A redirect from execute replaces the fetch
// PC. If a request is in flight when the redirect arrives, that request
// is allowed to finish and its data is thrown away (KILL state).
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   stall              hazard hold; blocks issue of a new request
//   redirect,
//   redirect_pc        execute-stage redirect strobe and target
//   imem_req,
//   imem_addr          memory request; address is stable while req=1
//   imem_ack,
//   imem_rdata         memory completion and instruction word
//   if_valid, if_pc,
//   if_inst            fetched instruction to decode
//   id_ready           decode accepts the instruction
//   busy               high whenever the sequencer is not IDLE
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  always_comb begin
    // NOTE: every value driven here gets a default first (hold current
    // value) so no path through the case leaves one unassigned and infers
    // a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (!stall) begin
          imem_addr_d = pc_q;
          imem_req_d  = 1'b1;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        // stall does not affect this state: an issued request always
        // runs to completion.
        if (imem_ack) begin
          imem_req_d = 1'b0;
          if (redirect) begin
            pc_d    = redirect_pc;
            state_d = IDLE;
          end else begin
            if_inst_d  = imem_rdata;
            if_pc_d    = imem_addr_q;
            if_valid_d = 1'b1;
            pc_d       = imem_addr_q + PC_STEP;
            state_d    = HOLD;
          end
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = KILL;
        end
      end

      HOLD: begin
        // Both a transfer and a redirect go through IDLE. The next issue
        // decision is made there, which gives the FETCH -> HOLD -> IDLE
        // rhythm of one instruction every three cycles.
        if (redirect) begin
          if_valid_d = 1'b0;
          pc_d       = redirect_pc;
          state_d    = IDLE;
        end else if (id_ready) begin
          if_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      KILL: begin
        // The squashed request keeps req and addr unchanged until its ack.
        // The latest redirect target wins.
        if (redirect) pc_d = redirect_pc;
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: synchronous reset takes priority over everything, including an
      // ack that lands during reset. Every state flop is reset because the
      // outputs must read zero.
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from
      // the values of the previous cycle.
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Inputs change 1 time unit after a rising edge. The bench checks outputs
// at that same point, so each check shows the result of the edge just taken.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .id_ready    (id_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    step(); step();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr,     32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc",    if_pc,         32'd0);
    check("rst_inst",  if_inst,       32'd0);
    check("rst_busy",  32'(busy),     32'd0);

    // Zero-wait memory, decode always ready.
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2402_0001; id_ready = 1'b1;
    step();
    check("zw_req",   32'(imem_req), 32'd1);
    check("zw_addr",  imem_addr,     32'h0);
    check("zw_busy",  32'(busy),     32'd1);
    step();
    check("zw_valid", 32'(if_valid), 32'd1);
    check("zw_pc",    if_pc,         32'h0);
    check("zw_inst",  if_inst,       32'h2402_0001);
    check("zw_req0",  32'(imem_req), 32'd0);
    step();
    check("zw_xfer_valid", 32'(if_valid), 32'd0);
    check("zw_idle_busy",  32'(busy),     32'd0);
    step();
    check("zw_next_req",  32'(imem_req), 32'd1);
    check("zw_next_addr", imem_addr,     32'h4);
    step();
    check("zw2_pc", if_pc, 32'h4);
    step();
    imem_ack = 1'b0;
    step();
    check("k_fetch_addr", imem_addr, 32'h8);

    // Redirect while FETCH with no ack goes to KILL.
    redirect = 1'b1; redirect_pc = 32'h400;
    step();
    check("k_req",  32'(imem_req), 32'd1);
    check("k_addr", imem_addr,     32'h8);
    check("k_busy", 32'(busy),     32'd1);
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    check("k_ack_valid", 32'(if_valid), 32'd0);
    check("k_ack_req",   32'(imem_req), 32'd0);
    imem_ack = 1'b0;
    step();
    check("k_next_req",  32'(imem_req), 32'd1);
    check("k_next_addr", imem_addr,     32'h400);

    // Ack and redirect together in FETCH: data dropped, PC becomes 0x10.
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h10;
    step();
    check("ar_valid", 32'(if_valid), 32'd0);
    check("ar_req",   32'(imem_req), 32'd0);
    imem_ack = 1'b0; redirect = 1'b0;
    step();
    check("d_req",  32'(imem_req), 32'd1);
    check("d_addr", imem_addr,     32'h10);

    // Three wait cycles with stall high: request stays unchanged.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("d_wait%0d_req", i), 32'(imem_req), 32'd1);
      check($sformatf("d_wait%0d_addr", i), imem_addr, 32'h10);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    step();
    check("d_valid", 32'(if_valid), 32'd1);
    check("d_pc",    if_pc,         32'h10);
    check("d_inst",  if_inst,       32'h1111_2222);
    imem_ack = 1'b0;
    step();
    check("d_xfer", 32'(if_valid), 32'd0);
    step();
    check("stall_noreq0", 32'(imem_req), 32'd0);
    step();
    check("stall_noreq1", 32'(imem_req), 32'd0);
    stall = 1'b0;
    step();
    check("unstall_req",  32'(imem_req), 32'd1);
    check("unstall_addr", imem_addr,     32'h14);

    // HOLD: keep the outputs while decode is not ready, then redirect with
    // id_ready=1.
    imem_ack = 1'b1; imem_rdata = 32'hABCD_0014; id_ready = 1'b0;
    step();
    check("h_valid", 32'(if_valid), 32'd1);
    step();
    check("h_keep_valid", 32'(if_valid), 32'd1);
    check("h_keep_pc",    if_pc,         32'h14);
    check("h_keep_inst",  if_inst,       32'hABCD_0014);
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    step();
    check("hr_valid", 32'(if_valid), 32'd0);
    check("hr_busy",  32'(busy),     32'd0);
    redirect = 1'b0; imem_ack = 1'b0;
    step();
    check("hr_next_addr", imem_addr, 32'h80);

    // Two redirects while in KILL: the last one wins.
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    check("kk_addr", imem_addr, 32'h80);
    redirect = 1'b0; imem_ack = 1'b1;
    step();
    check("kk_valid", 32'(if_valid), 32'd0);
    imem_ack = 1'b0;
    step();
    check("kk_next_addr", imem_addr, 32'h200);

    // Reset in the middle of KILL, with an ack arriving during reset.
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0; rst_n = 1'b0; imem_ack = 1'b1;
    step();
    check("mr_req",  32'(imem_req), 32'd0);
    check("mr_addr", imem_addr,     32'd0);
    check("mr_busy", 32'(busy),     32'd0);
    step();
    check("mr_valid", 32'(if_valid), 32'd0);
    check("mr_pc",    if_pc,         32'd0);
    check("mr_inst",  if_inst,       32'd0);
    rst_n = 1'b1; imem_ack = 1'b0;
    step();
    check("mr_first_req",  32'(imem_req), 32'd1);
    check("mr_first_addr", imem_addr,     32'h0);

    // PC wrap: redirect to 0xFFFF_FFFC. The next address after it is 0.
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    check("w_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("w_pc", if_pc, 32'hFFFF_FFFC);
    step();
    step();
    check("w_wrap_req",  32'(imem_req), 32'd1);
    check("w_wrap_addr", imem_addr,     32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
